// File: rtl/day_display_pkg.sv
// Shared constants for the day/week seven-segment display.
package day_display_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low one-hot digit enables
  localparam logic [1:0] AN_DAY  = 2'b10;
  localparam logic [1:0] AN_WEEK = 2'b01;
  localparam logic [1:0] AN_OFF  = 2'b11;

  // Any digit code above 9 decodes to a dash
  localparam logic [3:0] DIG_DASH = 4'hF;

  typedef enum logic {SEL_DAY, SEL_WEEK} sel_e;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder; codes >9 show a dash.
module seg7_decoder
  import day_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Table lookup, dash for anything outside 0..9
  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/day_display.sv
// Day/week display: detects the 6->0 day rollover, counts weeks, and
// time-multiplexes the day and week digits onto one segment bus.
module day_display
  import day_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int WEEK_MAX    = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] value,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       wrap,
  output logic [3:0] weeks,
  output logic       err
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [2:0]    value_q, prev_q;
  logic [CW-1:0] cnt;
  sel_e          sel_q, sel_d;
  logic          rf_term, wrap_d;
  logic [3:0]    digit;
  logic [6:0]    seg_d;

  assign rf_term = (cnt == CW'(REFRESH_DIV - 1));
  // Rollover seen on the registered pair; 6->6, 0->0, x->7, 7->0 all miss this
  assign wrap_d  = (value_q == 3'd0) && (prev_q == 3'd6);

  // Input sampling, rollover pulse, week count and sticky illegal-value flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
      prev_q  <= '0;
      wrap    <= 1'b0;
      weeks   <= '0;
      err     <= 1'b0;
    end else begin
      value_q <= value;
      prev_q  <= value_q;
      wrap    <= wrap_d;
      if (wrap_d)
        weeks <= (weeks == 4'(WEEK_MAX)) ? 4'd0 : weeks + 4'd1;
      if (value_q == 3'd7)
        err <= 1'b1;
    end
  end

  // Refresh slot counter, free-running 0..REFRESH_DIV-1
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= rf_term ? '0 : cnt + CW'(1);
  end

  // Digit-select state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sel_q <= SEL_DAY;
    else        sel_q <= sel_d;
  end

  // Next select and digit mux; an illegal day shows as a dash
  always_comb begin
    sel_d = sel_q;
    digit = weeks;
    if (rf_term)
      sel_d = (sel_q == SEL_DAY) ? SEL_WEEK : SEL_DAY;
    if (sel_q == SEL_DAY)
      digit = (value_q == 3'd7) ? DIG_DASH : {1'b0, value_q};
  end

  seg7_decoder u_dec (
    .digit (digit),
    .seg   (seg_d)
  );

  // Registered display outputs, blank while in reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
    end else begin
      seg <= seg_d;
      an  <= (sel_q == SEL_DAY) ? AN_DAY : AN_WEEK;
    end
  end

endmodule

// File: tb/tb_day_display.sv
// Directed bench for day_display with REFRESH_DIV=4, WEEK_MAX=2.
module tb_day_display;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] value;
  logic [6:0] seg;
  logic [1:0] an;
  logic       wrap;
  logic [3:0] weeks;
  logic       err;

  int total = 0;
  int bad   = 0;
  int e     = 0;   // rising edges since reset release
  int wcnt  = 0;   // wrap pulses seen

  day_display #(.REFRESH_DIV(4), .WEEK_MAX(2)) dut (
    .clock (clock),
    .reset (reset),
    .value (value),
    .seg   (seg),
    .an    (an),
    .wrap  (wrap),
    .weeks (weeks),
    .err   (err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!reset) e <= 0;
    else        e <= e + 1;
  end

  always @(negedge clock) if (wrap) wcnt++;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Spec segment table, independent of the RTL package
  function automatic int seg_code(input int n);
    case (n)
      0: return 'h40; 1: return 'h79; 2: return 'h24; 3: return 'h30;
      4: return 'h19; 5: return 'h12; 6: return 'h02; 7: return 'h78;
      8: return 'h00; 9: return 'h10;
      default: return 'h3F;
    endcase
  endfunction

  // After edge n the display shows the select held before that edge
  function automatic int exp_an(input int n);
    return ((((n - 1) / 4) % 2) == 0) ? 'b10 : 'b01;
  endfunction

  // Walk 1..6 then 0 from a current value of 0; check pulse timing and weeks
  task automatic day_cycle(input int exp_weeks);
    for (int i = 1; i <= 6; i++) begin
      value = 3'(i);
      cyc();
    end
    value = 3'd0;
    cyc();
    chk("wrap_early", wrap, 0);
    cyc();
    chk("wrap_pulse", wrap, 1);
    chk("weeks", weeks, exp_weeks);
    cyc();
    chk("wrap_clear", wrap, 0);
  endtask

  initial begin
    reset = 1'b0;
    value = 3'd0;
    #22;
    chk("rst_seg", seg, 'h7F);
    chk("rst_an", an, 'b11);
    chk("rst_wrap", wrap, 0);
    chk("rst_weeks", weeks, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;
    cyc();
    chk("rel_an", an, 'b10);
    chk("rel_seg", seg, 'h40);

    // Three full weeks with WEEK_MAX=2: 1, 2, back to 0
    day_cycle(1);
    chk("wrap_count_1", wcnt, 1);
    day_cycle(2);
    day_cycle(0);
    chk("wrap_count_3", wcnt, 3);

    // Multiplex: day=3, weeks=0
    value = 3'd3;
    cyc();
    cyc();
    for (int k = 0; k < 16; k++) begin
      cyc();
      chk("mux_an", an, exp_an(e));
      chk("mux_seg", seg, (exp_an(e) == 'b10) ? 'h30 : seg_code(0));
    end

    // Align so the cycle showing value 7 falls in a DAY slot
    for (int k = 0; k < 8 && ((((e + 2) / 4) % 2) != 0); k++) cyc();
    value = 3'd6;
    cyc();
    value = 3'd7;
    cyc();
    value = 3'd0;
    cyc();
    chk("dash_an", an, 'b10);
    chk("dash_seg", seg, 'h3F);
    chk("err_set", err, 1);
    cyc();
    chk("no_wrap_70", wrap, 0);
    repeat (6) cyc();
    chk("err_sticky", err, 1);
    chk("weeks_kept", weeks, 0);
    chk("wrap_count_err", wcnt, 3);

    // Get weeks nonzero, then reset in the middle of a pending wrap
    day_cycle(1);
    value = 3'd6;
    cyc();
    cyc();
    value = 3'd0;
    cyc();
    #2 reset = 1'b0;
    #1;
    chk("async_seg", seg, 'h7F);
    chk("async_an", an, 'b11);
    chk("async_wrap", wrap, 0);
    chk("async_weeks", weeks, 0);
    chk("async_err", err, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    cyc();
    chk("rerel_an", an, 'b10);
    chk("rerel_seg", seg, 'h40);
    chk("rerel_wrap", wrap, 0);
    repeat (4) cyc();
    chk("no_wrap_after_rst", wcnt, 4);
    chk("weeks_after_rst", weeks, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/day_display.md
DAY_DISPLAY -- requirements
Module: day_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, SHALL set the clock cycles per digit-multiplex slot (legal range 2..2^20).
REQ-002 Parameter WEEK_MAX, default 9, SHALL set the terminal value of the week counter (legal range 1..9).
REQ-003 clock  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous and active-low: reset=0 clears all state immediately, independent of clock.
REQ-005 value  input  3  SHALL carry the mod-7 day count (legal 0..6) from the upstream counter.
REQ-006 seg  output  7  SHALL drive the segments {g,f,e,d,c,b,a}, active-low.
REQ-007 an  output  2  SHALL select the digit, active-low one-hot: an[0] is the day digit, an[1] is the week digit.
REQ-008 wrap  output  1  SHALL be a one-cycle pulse on each day 6 -> 0 transition.
REQ-009 weeks  output  4  SHALL carry the completed-week count, 0..WEEK_MAX.
REQ-010 err  output  1  SHALL be a sticky flag set when an illegal value (7) is sampled.

Function
REQ-011 value SHALL be registered into value_q every cycle; the previous value_q SHALL be held in prev_q.
REQ-012 wrap SHALL assert in the cycle after value_q becomes 0 while prev_q equals 6, and only then.
REQ-013 The transitions 6->6, 0->0, any -> 7, and 7 -> 0 SHALL NOT produce wrap.
REQ-014 weeks SHALL increment on each wrap; at WEEK_MAX, a wrap SHALL return weeks to 0 (modulo WEEK_MAX+1).
REQ-015 err SHALL set when value_q equals 7 and SHALL stay set until reset; it SHALL NOT freeze the other logic.
REQ-016 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; at its terminal count, the digit select SHALL toggle.
REQ-017 Digit select state machine: DAY (an=2'b10, seg=code(value_q)) <-> WEEK (an=2'b01, seg=code(weeks)); it SHALL toggle only at refresh terminal.
REQ-018 Segment codes (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-019 When value_q equals 7, the DAY digit SHALL show dash 3F.
REQ-020 seg and an SHALL be registered; a value change SHALL appear on seg 2 cycles after the input edge while DAY is selected.
REQ-021 A wrap coinciding with a refresh terminal SHALL apply both; the WEEK digit SHALL show the updated weeks from the following cycle.

Reset
REQ-022 While reset=0: seg=7F (blank), an=2'b11, wrap=0, weeks=0, err=0, value_q=0, prev_q=0, refresh count=0, select=DAY.
REQ-023 After reset release, the first refresh slot SHALL be DAY, starting REFRESH_DIV cycles before the first toggle.
REQ-024 Reset asserted mid-slot or mid-wrap SHALL clear state immediately; no wrap pulse SHALL be emitted for the interrupted transition.

Structure
REQ-025 A shared package day_display_pkg SHALL hold the segment-code constants (including DASH and BLANK) and the digit-select enum {SEL_DAY, SEL_WEEK}.
REQ-026 A purely combinational sub-module seg7_decoder (4-bit in, 7-bit active-low out, dash for codes >9) SHALL be instantiated once, fed by the select mux.

Verification (bench: REFRESH_DIV=4, WEEK_MAX=2)
REQ-027 Reset, then release: seg=7F, an=11 during reset; 1 cycle after release, an=10, seg=40.
REQ-028 Drive value 0..6 then 0, one per cycle: exactly one wrap pulse, 2 cycles after the 0 is applied; weeks=1.
REQ-029 Produce three full 0..6 cycles: weeks goes 1, 2, 0; wrap pulses=3.
REQ-030 Hold value=3 for 16 cycles: an alternates 10/01 every 4 cycles; seg alternates 30 / code(weeks).
REQ-031 Drive 6, 7, 0: err=1 and stays set, DAY digit shows 3F, no wrap, weeks unchanged.
REQ-032 Assert reset asynchronously between clock edges while value goes 6 -> 0: outputs clear before the next edge, and no wrap is emitted after release.
